// File: rtl/key_loader_if.sv
// key_loader_if: groups the serial key stream handshake and the key outputs.
// Handshake: a key bit moves from master to slave only on a rising clock edge
// where key_in_valid and key_in_ready are both 1; the master holds key_in
// stable while key_in_valid is high and the slave is not yet ready.
interface key_loader_if #(
    parameter int NUM_KEYS = 2
) ();
    logic                load_start;
    logic                key_in;
    logic                key_in_valid;
    logic                key_in_ready;
    logic [NUM_KEYS-1:0] key_out;
    logic                key_done;
    logic                load_err;

    // Key source side: drives the stream, observes the loader result.
    modport master (
        output load_start, key_in, key_in_valid,
        input  key_in_ready, key_out, key_done, load_err
    );

    // Loader side: accepts the stream, drives the key towards locked logic.
    modport slave (
        input  load_start, key_in, key_in_valid,
        output key_in_ready, key_out, key_done, load_err
    );
endinterface

// File: rtl/key_loader.sv
// key_loader: assembles a serial key stream LSB-first into a NUM_KEYS-bit
// register and presents it on key_out only after a complete, checked load.
// Optional feature macro: KEY_PARITY_EN adds one even-parity bit after the
// key (PAR state); a mismatch ends in ERR with load_err set. Without the
// macro, DONE follows the last key bit directly and load_err stays 0.
// state_dbg exposes the FSM state encoding for observation.
module key_loader #(
    parameter int NUM_KEYS = 2,
    parameter int ONE_TIME = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    key_loader_if.slave  bus,
    output logic [2:0]   state_dbg
);
    localparam int CNT_W = $clog2(NUM_KEYS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PAR  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] shreg;
    logic [NUM_KEYS-1:0] shreg_next;
    logic [CNT_W-1:0]    cnt;
    logic                xfer;
    logic                last_bit;

    assign xfer      = bus.key_in_valid & bus.key_in_ready;
    assign last_bit  = (cnt == CNT_W'(NUM_KEYS - 1));
    assign state_dbg = state;

    // Shift register with the incoming bit placed at the current count.
    always_comb begin
        shreg_next = shreg;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (cnt == CNT_W'(i)) shreg_next[i] = bus.key_in;
        end
    end

    // Load FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            shreg            <= '0;
            cnt              <= '0;
            bus.key_out      <= '0;
            bus.key_done     <= 1'b0;
            bus.load_err     <= 1'b0;
            bus.key_in_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        state            <= S_LOAD;
                        shreg            <= '0;
                        cnt              <= '0;
                        bus.key_in_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A restart wins over a bit presented in the same cycle.
                    if (bus.load_start) begin
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (xfer) begin
                        shreg <= shreg_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_bit) begin
`ifdef KEY_PARITY_EN
                            state <= S_PAR;
`else
                            state            <= S_DONE;
                            bus.key_in_ready <= 1'b0;
                            bus.key_out      <= shreg_next;
                            bus.key_done     <= 1'b1;
`endif
                        end
                    end
                end
`ifdef KEY_PARITY_EN
                S_PAR: begin
                    if (bus.load_start) begin
                        state <= S_LOAD;
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (xfer) begin
                        bus.key_in_ready <= 1'b0;
                        if (bus.key_in == ^shreg) begin
                            state        <= S_DONE;
                            bus.key_out  <= shreg;
                            bus.key_done <= 1'b1;
                        end else begin
                            state        <= S_ERR;
                            bus.load_err <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    // Write-once builds keep the key until reset.
                    if (bus.load_start && (ONE_TIME == 0)) begin
                        state            <= S_LOAD;
                        shreg            <= '0;
                        cnt              <= '0;
                        bus.key_out      <= '0;
                        bus.key_done     <= 1'b0;
                        bus.key_in_ready <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (bus.load_start) begin
                        state            <= S_LOAD;
                        shreg            <= '0;
                        cnt              <= '0;
                        bus.load_err     <= 1'b0;
                        bus.key_in_ready <= 1'b1;
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    bus.key_in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: drives three loaders (2-bit re-keyable, 2-bit write-once,
// 8-bit) from one shared stream gated by sel; completed loads are checked
// against an expected queue filled as each load is driven.
module tb_key_loader;
    logic       clk;
    logic       rst_n;
    int         sel;
    logic       load_start;
    logic       key_in;
    logic       key_in_valid;
    logic [2:0] st2, st2o, st8;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];
    logic [2:0] prev_done = '0;
    logic [2:0] prev_err  = '0;

    key_loader_if #(.NUM_KEYS(2)) if2  ();
    key_loader_if #(.NUM_KEYS(2)) if2o ();
    key_loader_if #(.NUM_KEYS(8)) if8  ();

    assign if2.load_start    = load_start   && (sel == 0);
    assign if2.key_in_valid  = key_in_valid && (sel == 0);
    assign if2.key_in        = key_in;
    assign if2o.load_start   = load_start   && (sel == 1);
    assign if2o.key_in_valid = key_in_valid && (sel == 1);
    assign if2o.key_in       = key_in;
    assign if8.load_start    = load_start   && (sel == 2);
    assign if8.key_in_valid  = key_in_valid && (sel == 2);
    assign if8.key_in        = key_in;

    key_loader #(.NUM_KEYS(2), .ONE_TIME(0)) u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave),  .state_dbg(st2));
    key_loader #(.NUM_KEYS(2), .ONE_TIME(1)) u_dut2o (.clk(clk), .rst_n(rst_n), .bus(if2o.slave), .state_dbg(st2o));
    key_loader #(.NUM_KEYS(8), .ONE_TIME(0)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave),  .state_dbg(st8));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Readback of the currently selected loader
    logic       rd_ready, rd_done, rd_err;
    logic [7:0] rd_key;
    always_comb begin
        rd_ready = 1'b0;
        rd_done  = 1'b0;
        rd_err   = 1'b0;
        rd_key   = '0;
        case (sel)
            0: begin rd_ready = if2.key_in_ready;  rd_done = if2.key_done;  rd_err = if2.load_err;  rd_key = {6'b0, if2.key_out};  end
            1: begin rd_ready = if2o.key_in_ready; rd_done = if2o.key_done; rd_err = if2o.load_err; rd_key = {6'b0, if2o.key_out}; end
            default: begin rd_ready = if8.key_in_ready; rd_done = if8.key_done; rd_err = if8.load_err; rd_key = if8.key_out; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: a rising key_done or load_err is one completed load.
    task automatic observe(input int d, input logic done, input logic err, input logic [7:0] key);
        logic [9:0] e;
        if ((done && !prev_done[d]) || (err && !prev_err[d])) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({err, done, key}), 32'(e));
            end
        end
        prev_done[d] = done;
        prev_err[d]  = err;
    endtask

    always @(negedge clk) begin
        observe(0, if2.key_done,  if2.load_err,  {6'b0, if2.key_out});
        observe(1, if2o.key_done, if2o.load_err, {6'b0, if2o.key_out});
        observe(2, if8.key_done,  if8.load_err,  if8.key_out);
    end

    // Driver tasks; all start and end on a falling edge.
    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        check("ready_in_load", 32'(rd_ready), 32'd1);
        key_in       = b;
        key_in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_par(input logic [7:0] v, input bit bad);
`ifdef KEY_PARITY_EN
        send_bit(bad ? ~^v : ^v);
`else
        if (bad) $display("note: parity error requested in a build without parity");
`endif
    endtask

    function automatic logic [9:0] expect_of(input logic [7:0] v, input bit bad);
        return bad ? {1'b1, 1'b0, 8'h00} : {1'b0, 1'b1, v};
    endfunction

    task automatic load_key(input int width, input logic [7:0] v, input bit bad);
        exp_q.push_back(expect_of(v, bad));
        pulse_start();
        for (int i = 0; i < width; i++) send_bit(v[i]);
        send_par(v, bad);
        key_in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({rd_ready, rd_done, rd_err, rd_key}), 32'd0);
    endtask

    // Main sequence
    initial begin
        logic [7:0] r;
        rst_n = 1'b0; sel = 0; load_start = 1'b0; key_in = 1'b0; key_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check_all_zero("reset_outputs");
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load 1,0 with valid held high afterwards
        load_key(2, 8'h01, 0);
        check("basic_key", 32'(rd_key), 32'h01);
        check("basic_done", 32'(rd_done), 32'd1);
        key_in_valid = 1'b1; key_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_ready_low", 32'(rd_ready), 32'd0);
            check("hold_key_stable", 32'(rd_key), 32'h01);
        end
        key_in_valid = 1'b0;

`ifdef KEY_PARITY_EN
        load_key(2, 8'h03, 0);
        check("par_ok_key", 32'(rd_key), 32'h03);
        load_key(2, 8'h03, 1);
        check("par_bad_err", 32'(rd_err), 32'd1);
        check("par_bad_key", 32'({rd_done, rd_key}), 32'd0);
        load_key(2, 8'h01, 0);
        check("par_err_cleared", 32'(rd_err), 32'd0);
`endif

        // Valid gaps
        exp_q.push_back(expect_of(8'h02, 0));
        pulse_start();
        send_bit(1'b0);
        key_in_valid = 1'b0; key_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("gap_not_done", 32'(rd_done), 32'd0);
        end
        send_bit(1'b1);
        send_par(8'h02, 0);
        key_in_valid = 1'b0;
        check("gap_key", 32'(rd_key), 32'h02);

        // Restart mid-load discards the partial key and the same-cycle bit
        exp_q.push_back(expect_of(8'h03, 0));
        pulse_start();
        send_bit(1'b1);
        load_start = 1'b1; key_in = 1'b0; key_in_valid = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("restart_not_done", 32'(rd_done), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_par(8'h03, 0);
        key_in_valid = 1'b0;
        check("restart_key", 32'(rd_key), 32'h03);

        // Re-key on the re-keyable loader
        load_key(2, 8'h01, 0);
        pulse_start();
        check("rekey_key_cleared", 32'(rd_key), 32'h00);
        check("rekey_done_cleared", 32'(rd_done), 32'd0);
        check("rekey_ready", 32'(rd_ready), 32'd1);

        // Write-once loader ignores load_start in DONE
        sel = 1;
        load_key(2, 8'h01, 0);
        pulse_start();
        repeat (2) begin
            check("once_key_kept", 32'(rd_key), 32'h01);
            check("once_done_kept", 32'(rd_done), 32'd1);
            check("once_ready_low", 32'(rd_ready), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset mid-load, then in DONE
        sel = 0;
        pulse_start();
        send_bit(1'b1);
        key_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_load");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_key(2, 8'h01, 0);
        check("after_reset_key", 32'(rd_key), 32'h01);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_in_done");
        sel = 1;
        check_all_zero("reset_once_loader");
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_key(2, 8'h02, 0);
        check("after_reset2_key", 32'(rd_key), 32'h02);

        // 8-bit loader
        sel = 2;
        load_key(8, 8'hA5, 0);
        check("wide_key", 32'(rd_key), 32'hA5);
        for (int n = 0; n < 4; n++) begin
            r = 8'($urandom_range(0, 255));
            load_key(8, r, 0);
            check("wide_rand_key", 32'(rd_key), 32'(r));
        end
        sel = 0;
        for (int n = 0; n < 4; n++) begin
            r = 8'($urandom_range(0, 3));
            load_key(2, r, 0);
            check("narrow_rand_key", 32'(rd_key), 32'(r));
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
